// File: rtl/prbs_err_monitor.sv
// PRBS error monitor: drives the checker enable, flushes its pipeline, acquires lock
// on a clean run and counts error cycles over a programmable measurement window.
module prbs_err_monitor #(
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned SYNC_TO    = 1024,
  parameter int unsigned WIN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [WIN_WIDTH-1:0] win_len_i,
  input  logic                 prbs_chk_error_i,
  output logic                 prbs_en_o,
  output logic                 busy_o,
  output logic                 locked_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 sync_fail_o
);

  typedef enum logic [2:0] {StIdle, StFlush, StSync, StMeasure, StDone} state_e;

  localparam logic [7:0]  LockTgt   = 8'(LOCK_CNT);
  localparam logic [7:0]  UnlockTgt = 8'(UNLOCK_CNT);
  localparam logic [15:0] SyncTgt   = 16'(SYNC_TO);

  state_e               state_q, state_d;
  logic [1:0]           flushCnt_q, flushCnt_d;
  logic [7:0]           cleanCnt_q, cleanCnt_d;
  logic [7:0]           errRun_q, errRun_d;
  logic [15:0]          syncCnt_q, syncCnt_d;
  logic [WIN_WIDTH-1:0] winCnt_q, winCnt_d;
  logic [WIN_WIDTH-1:0] winLen_q, winLen_d;
  logic [CNT_WIDTH-1:0] errCnt_q, errCnt_d;
  logic                 locked_q, locked_d;
  logic                 pass_q, pass_d;
  logic                 syncFail_q, syncFail_d;
  logic                 busy_q, busy_d;
  logic                 prbsEn_q, prbsEn_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d    = state_q;
    flushCnt_d = flushCnt_q;
    cleanCnt_d = cleanCnt_q;
    errRun_d   = errRun_q;
    syncCnt_d  = syncCnt_q;
    winCnt_d   = winCnt_q;
    winLen_d   = winLen_q;
    errCnt_d   = errCnt_q;
    locked_d   = locked_q;
    pass_d     = pass_q;
    syncFail_d = syncFail_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StFlush;
          winLen_d   = (win_len_i == '0) ? WIN_WIDTH'(1) : win_len_i;
          flushCnt_d = '0;
          cleanCnt_d = '0;
          errRun_d   = '0;
          syncCnt_d  = '0;
          winCnt_d   = '0;
          errCnt_d   = '0;
          locked_d   = 1'b0;
          pass_d     = 1'b0;
          syncFail_d = 1'b0;
        end
      end
      // The checker flag is meaningless here: it starts high and lags data by two cycles.
      StFlush: begin
        flushCnt_d = flushCnt_q + 2'd1;
        if (flushCnt_q == 2'd2) state_d = StSync;
      end
      StSync: begin
        cleanCnt_d = prbs_chk_error_i ? 8'd0 : cleanCnt_q + 8'd1;
        syncCnt_d  = syncCnt_q + 16'd1;
        if (!prbs_chk_error_i && (cleanCnt_q + 8'd1 == LockTgt)) begin
          locked_d = 1'b1;
          state_d  = StMeasure;
        end else if (syncCnt_q + 16'd1 == SyncTgt) begin
          syncFail_d = 1'b1;
          state_d    = StDone;
        end
      end
      StMeasure: begin
        if (prbs_chk_error_i) begin
          if (errCnt_q != '1) errCnt_d = errCnt_q + CNT_WIDTH'(1);
          if (errRun_q != UnlockTgt) errRun_d = errRun_q + 8'd1;
          if (errRun_d == UnlockTgt) locked_d = 1'b0;
        end else begin
          errRun_d = '0;
        end
        winCnt_d = winCnt_q + WIN_WIDTH'(1);
        if (winCnt_q + WIN_WIDTH'(1) == winLen_q) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort freezes the reported results exactly as they stood when it was seen.
    if (abort_i) begin
      state_d    = StIdle;
      errCnt_d   = errCnt_q;
      locked_d   = locked_q;
      pass_d     = pass_q;
      syncFail_d = syncFail_q;
    end

    if (state_d == StDone && state_q != StDone)
      pass_d = locked_d && (errCnt_d == '0) && !syncFail_d;

    busy_d   = (state_d != StIdle);
    prbsEn_d = (state_d == StFlush) || (state_d == StSync) || (state_d == StMeasure);
    done_d   = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= StIdle;
      flushCnt_q <= '0;
      cleanCnt_q <= '0;
      errRun_q   <= '0;
      syncCnt_q  <= '0;
      winCnt_q   <= '0;
      winLen_q   <= '0;
      errCnt_q   <= '0;
      locked_q   <= 1'b0;
      pass_q     <= 1'b0;
      syncFail_q <= 1'b0;
      busy_q     <= 1'b0;
      prbsEn_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      flushCnt_q <= flushCnt_d;
      cleanCnt_q <= cleanCnt_d;
      errRun_q   <= errRun_d;
      syncCnt_q  <= syncCnt_d;
      winCnt_q   <= winCnt_d;
      winLen_q   <= winLen_d;
      errCnt_q   <= errCnt_d;
      locked_q   <= locked_d;
      pass_q     <= pass_d;
      syncFail_q <= syncFail_d;
      busy_q     <= busy_d;
      prbsEn_q   <= prbsEn_d;
      done_q     <= done_d;
    end
  end

  assign prbs_en_o   = prbsEn_q;
  assign busy_o      = busy_q;
  assign locked_o    = locked_q;
  assign err_cnt_o   = errCnt_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign sync_fail_o = syncFail_q;

endmodule

// File: tb/tb_prbs_err_monitor.sv
// Bench for prbs_err_monitor: each run's error pattern is fed to a default instance and a
// 4-bit-counter instance, and every cycle is compared against a run-level timeline model.
module tb_prbs_err_monitor;

  localparam int MaxC    = 2048;
  localparam int LockC   = 16;
  localparam int UnlockC = 4;
  localparam int SyncTo  = 1024;

  logic        clk_i = 1'b0;
  logic        resetn_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        prbs_chk_error_i = 1'b0;
  logic [15:0] win_len_i = 16'd0;
  logic        prbs_en_o, busy_o, locked_o, done_o, pass_o, sync_fail_o;
  logic [15:0] err_cnt_o;
  logic        enS, busyS, lockedS, doneS, passS, sfS;
  logic [3:0]  cntS;

  int vectors = 0;
  int miscompares = 0;

  bit          errPat [MaxC];
  logic [15:0] winLen;
  int          abortCyc, doneCyc, endC;
  logic [5:0]  expFlags [MaxC];
  logic [5:0]  actFlags [MaxC];
  logic [5:0]  actFlagsS [MaxC];
  logic [15:0] expCnt [MaxC];
  logic [15:0] actCnt [MaxC];
  logic [3:0]  expCntS [MaxC];
  logic [3:0]  actCntS [MaxC];

  always #5 clk_i = ~clk_i;

  prbs_err_monitor dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .start_i(start_i), .abort_i(abort_i),
    .win_len_i(win_len_i), .prbs_chk_error_i(prbs_chk_error_i),
    .prbs_en_o(prbs_en_o), .busy_o(busy_o), .locked_o(locked_o), .err_cnt_o(err_cnt_o),
    .done_o(done_o), .pass_o(pass_o), .sync_fail_o(sync_fail_o)
  );

  prbs_err_monitor #(.CNT_WIDTH(4)) dutSmall (
    .clk_i(clk_i), .resetn_i(resetn_i), .start_i(start_i), .abort_i(abort_i),
    .win_len_i(win_len_i), .prbs_chk_error_i(prbs_chk_error_i),
    .prbs_en_o(enS), .busy_o(busyS), .locked_o(lockedS), .err_cnt_o(cntS),
    .done_o(doneS), .pass_o(passS), .sync_fail_o(sfS)
  );

  // Pattern index c is the error flag sampled at edge c of a run (edge 0 samples start).
  function automatic void clearPattern();
    for (int i = 0; i < MaxC; i++) errPat[i] = 1'b0;
    for (int i = 0; i < 4; i++) errPat[i] = 1'($urandom);
    abortCyc = 0;
  endfunction

  // Timeline model: find the lock (or timeout) cycle, the window and the unlock cycle,
  // then derive what every output must show in each cycle of the run.
  function automatic void buildModel();
    int lockC = 0, failC = 0, unlockC = 0, run = 0, cons = 0, errs = 0;
    int weff, msStart, msEnd;
    bit lk, ps, sf;
    weff = (winLen == 16'd0) ? 1 : int'(winLen);
    for (int c = 4; c <= 3 + SyncTo; c++) begin
      run = errPat[c] ? 0 : run + 1;
      if (run == LockC) begin lockC = c; break; end
    end
    if (lockC == 0) begin
      failC = 3 + SyncTo; doneCyc = failC + 1; msStart = 1; msEnd = 0;
    end else begin
      msStart = lockC + 1; msEnd = lockC + weff; doneCyc = msEnd + 1;
      for (int m = msStart; m <= msEnd; m++) begin
        cons = errPat[m] ? cons + 1 : 0;
        if (cons == UnlockC && unlockC == 0) unlockC = m;
      end
    end
    endC = (abortCyc > 0) ? abortCyc + 3 : doneCyc + 1;
    for (int c = 1; c <= endC; c++) begin
      if (c - 1 >= msStart && c - 1 <= msEnd && errPat[c-1]) errs++;
      lk = (lockC > 0) && (c > lockC) && !(unlockC > 0 && c > unlockC);
      sf = (failC > 0) && (c >= doneCyc);
      ps = (c >= doneCyc) && (lockC > 0) && (errs == 0);
      expFlags[c] = {c <= doneCyc, c < doneCyc, c == doneCyc, lk, ps, sf};
      expCnt[c]   = (errs > 65535) ? 16'hFFFF : 16'(errs);
      expCntS[c]  = (errs > 15) ? 4'hF : 4'(errs);
    end
    if (abortCyc > 0)
      for (int c = abortCyc + 1; c <= endC; c++) begin
        expFlags[c] = {3'b000, expFlags[abortCyc][2:0]};
        expCnt[c]   = expCnt[abortCyc];
        expCntS[c]  = expCntS[abortCyc];
      end
  endfunction

  // Drives one run and records what both instances show in cycles 1..endC.
  task automatic driveRun(input bit hold);
    for (int k = 0; k < endC; k++) begin
      start_i          = (k == 0) || hold;
      abort_i          = (abortCyc > 0) && (k == abortCyc);
      prbs_chk_error_i = errPat[k];
      win_len_i        = (k == 0) ? winLen : 16'($urandom);
      @(posedge clk_i); #1;
      actFlags[k+1]  = {busy_o, prbs_en_o, done_o, locked_o, pass_o, sync_fail_o};
      actFlagsS[k+1] = {busyS, enS, doneS, lockedS, passS, sfS};
      actCnt[k+1]    = err_cnt_o;
      actCntS[k+1]   = cntS;
    end
    start_i = hold;
    abort_i = 1'b0;
  endtask

  task automatic idle(input int n);
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (n) begin
      prbs_chk_error_i = 1'($urandom);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if ({busy_o, prbs_en_o, done_o, locked_o, pass_o, sync_fail_o, err_cnt_o} !== 22'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_main: got %b, expected all zero",
               {busy_o, prbs_en_o, done_o, locked_o, pass_o, sync_fail_o, err_cnt_o});
    end
    vectors++;
    if ({busyS, enS, doneS, lockedS, passS, sfS, cntS} !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_small: got %b, expected all zero",
               {busyS, enS, doneS, lockedS, passS, sfS, cntS});
    end
    resetn_i = 1'b1;
    idle(3);
    vectors++;
    if ({busy_o, prbs_en_o, done_o, locked_o, pass_o, sync_fail_o, err_cnt_o} !== 22'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got %b, expected all zero",
               {busy_o, prbs_en_o, done_o, locked_o, pass_o, sync_fail_o, err_cnt_o});
    end
  endtask

  task automatic test_clean_run();
    clearPattern(); winLen = 16'd100; buildModel(); driveRun(1'b0);
    for (int c = 1; c <= endC; c++) begin
      vectors++;
      if (actFlags[c] !== expFlags[c] || actFlagsS[c] !== expFlags[c] || actCnt[c] !== expCnt[c] || actCntS[c] !== expCntS[c]) begin
        miscompares++;
        $display("[TB] FAIL clean_run c=%0d: got %b/%b cnt %0d/%0d, expected %b cnt %0d/%0d",
                 c, actFlags[c], actFlagsS[c], actCnt[c], actCntS[c], expFlags[c], expCnt[c], expCntS[c]);
      end
    end
    vectors++;
    if ({actFlags[19][2], actFlags[20][2], actFlags[119][3], actFlags[120][3],
         actFlags[119][4], actFlags[120][4], actFlags[120][1], actCnt[120]} !== {7'b0101101, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL clean_timing: lock19/20=%b%b done119/120=%b%b en119/120=%b%b pass=%b cnt=%0d, expected 01 01 10 1 0",
               actFlags[19][2], actFlags[20][2], actFlags[119][3], actFlags[120][3],
               actFlags[119][4], actFlags[120][4], actFlags[120][1], actCnt[120]);
    end
    idle(2);
  endtask

  task automatic test_isolated_errors();
    clearPattern(); winLen = 16'd100;
    for (int i = 0; i < 5; i++) errPat[30 + 15*i + $urandom_range(0, 5)] = 1'b1;
    buildModel(); driveRun(1'b0);
    for (int c = 1; c <= endC; c++) begin
      vectors++;
      if (actFlags[c] !== expFlags[c] || actFlagsS[c] !== expFlags[c] || actCnt[c] !== expCnt[c] || actCntS[c] !== expCntS[c]) begin
        miscompares++;
        $display("[TB] FAIL isolated_errors c=%0d: got %b/%b cnt %0d/%0d, expected %b cnt %0d/%0d",
                 c, actFlags[c], actFlagsS[c], actCnt[c], actCntS[c], expFlags[c], expCnt[c], expCntS[c]);
      end
    end
    vectors++;
    if ({actCnt[120], actFlags[120][2], actFlags[120][1]} !== {16'd5, 2'b10}) begin
      miscompares++;
      $display("[TB] FAIL isolated_result: cnt=%0d locked=%b pass=%b, expected 5 1 0",
               actCnt[120], actFlags[120][2], actFlags[120][1]);
    end
    idle(2);
  endtask

  task automatic test_sync_timeout();
    clearPattern(); winLen = 16'd50;
    for (int c = 4; c < MaxC; c++) errPat[c] = 1'b1;
    buildModel(); driveRun(1'b0);
    for (int c = 1; c <= endC; c++) begin
      vectors++;
      if (actFlags[c] !== expFlags[c] || actFlagsS[c] !== expFlags[c] || actCnt[c] !== expCnt[c] || actCntS[c] !== expCntS[c]) begin
        miscompares++;
        $display("[TB] FAIL sync_timeout c=%0d: got %b/%b cnt %0d/%0d, expected %b cnt %0d/%0d",
                 c, actFlags[c], actFlagsS[c], actCnt[c], actCntS[c], expFlags[c], expCnt[c], expCntS[c]);
      end
    end
    vectors++;
    if ({actFlags[1027][3], actFlags[1028][3], actFlags[1028][0], actFlags[1028][2], actFlags[1028][1], actCnt[1028]} !== {5'b01100, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL timeout_result: done1027/1028=%b%b sf=%b locked=%b pass=%b cnt=%0d, expected 01 1 0 0 0",
               actFlags[1027][3], actFlags[1028][3], actFlags[1028][0], actFlags[1028][2], actFlags[1028][1], actCnt[1028]);
    end
    idle(2);
  endtask

  task automatic test_unlock_and_saturate();
    for (int pass = 0; pass < 2; pass++) begin
      clearPattern(); winLen = 16'd100;
      if (pass == 0) begin
        for (int c = 40; c < 44; c++) errPat[c] = 1'b1;
        for (int c = 50; c < 120; c++) errPat[c] = ($urandom_range(9) == 0);
      end else begin
        for (int c = 50; c < 90; c++) errPat[c] = 1'b1;
      end
      buildModel(); driveRun(1'b0);
      for (int c = 1; c <= endC; c++) begin
        vectors++;
        if (actFlags[c] !== expFlags[c] || actFlagsS[c] !== expFlags[c] || actCnt[c] !== expCnt[c] || actCntS[c] !== expCntS[c]) begin
          miscompares++;
          $display("[TB] FAIL unlock_sat%0d c=%0d: got %b/%b cnt %0d/%0d, expected %b cnt %0d/%0d",
                   pass, c, actFlags[c], actFlagsS[c], actCnt[c], actCntS[c], expFlags[c], expCnt[c], expCntS[c]);
        end
      end
      vectors++;
      if (pass == 0 && {actFlags[43][2], actFlags[44][2], actFlags[120][1]} !== 3'b100) begin
        miscompares++;
        $display("[TB] FAIL unlock_edge: locked43/44=%b%b pass=%b, expected 10 0",
                 actFlags[43][2], actFlags[44][2], actFlags[120][1]);
      end else if (pass == 1 && {actCnt[120], actCntS[120]} !== {16'd40, 4'd15}) begin
        miscompares++;
        $display("[TB] FAIL saturate: cnt=%0d small=%0d, expected 40 15", actCnt[120], actCntS[120]);
      end
      idle(2);
    end
  endtask

  task automatic test_zero_window();
    clearPattern(); winLen = 16'd0; buildModel(); driveRun(1'b0);
    for (int c = 1; c <= endC; c++) begin
      vectors++;
      if (actFlags[c] !== expFlags[c] || actFlagsS[c] !== expFlags[c] || actCnt[c] !== expCnt[c] || actCntS[c] !== expCntS[c]) begin
        miscompares++;
        $display("[TB] FAIL zero_window c=%0d: got %b/%b cnt %0d/%0d, expected %b cnt %0d/%0d",
                 c, actFlags[c], actFlagsS[c], actCnt[c], actCntS[c], expFlags[c], expCnt[c], expCntS[c]);
      end
    end
    vectors++;
    if ({actFlags[20][3], actFlags[21][3]} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL zero_window_done: done20/21=%b%b, expected 01", actFlags[20][3], actFlags[21][3]);
    end
    idle(2);
  endtask

  task automatic test_abort();
    clearPattern(); winLen = 16'd100;
    errPat[30] = 1'b1; errPat[31] = 1'b1; errPat[40] = 1'b1;
    abortCyc = 40;
    buildModel(); driveRun(1'b0);
    for (int c = 1; c <= endC; c++) begin
      vectors++;
      if (actFlags[c] !== expFlags[c] || actFlagsS[c] !== expFlags[c] || actCnt[c] !== expCnt[c] || actCntS[c] !== expCntS[c]) begin
        miscompares++;
        $display("[TB] FAIL abort c=%0d: got %b/%b cnt %0d/%0d, expected %b cnt %0d/%0d",
                 c, actFlags[c], actFlagsS[c], actCnt[c], actCntS[c], expFlags[c], expCnt[c], expCntS[c]);
      end
    end
    vectors++;
    if ({actFlags[41], actCnt[41]} !== {6'b000100, 16'd2}) begin
      miscompares++;
      $display("[TB] FAIL abort_hold: flags=%b cnt=%0d, expected 000100 2", actFlags[41], actCnt[41]);
    end
    idle(2);
  endtask

  task automatic test_random();
    int dens;
    for (int r = 0; r < 6; r++) begin
      clearPattern();
      dens = (r % 4 == 0) ? 0 : (r % 4 == 1) ? 3 : (r % 4 == 2) ? 8 : 15;
      for (int c = 4; c < MaxC; c++) errPat[c] = ($urandom_range(99) < dens);
      winLen = 16'($urandom_range(1, 200));
      buildModel(); driveRun(1'b0);
      for (int c = 1; c <= endC; c++) begin
        vectors++;
        if (actFlags[c] !== expFlags[c] || actFlagsS[c] !== expFlags[c] || actCnt[c] !== expCnt[c] || actCntS[c] !== expCntS[c]) begin
          miscompares++;
          $display("[TB] FAIL random%0d c=%0d: got %b/%b cnt %0d/%0d, expected %b cnt %0d/%0d",
                   r, c, actFlags[c], actFlagsS[c], actCnt[c], actCntS[c], expFlags[c], expCnt[c], expCntS[c]);
        end
      end
      idle(2);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      clearPattern();
      for (int c = 4; c < MaxC; c++) errPat[c] = (r == 1) && ($urandom_range(99) < 5);
      winLen = 16'($urandom_range(5, 40));
      buildModel(); driveRun(r == 0);
      for (int c = 1; c <= endC; c++) begin
        vectors++;
        if (actFlags[c] !== expFlags[c] || actFlagsS[c] !== expFlags[c] || actCnt[c] !== expCnt[c] || actCntS[c] !== expCntS[c]) begin
          miscompares++;
          $display("[TB] FAIL back_to_back%0d c=%0d: got %b/%b cnt %0d/%0d, expected %b cnt %0d/%0d",
                   r, c, actFlags[c], actFlagsS[c], actCnt[c], actCntS[c], expFlags[c], expCnt[c], expCntS[c]);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_reset_midrun();
    start_i = 1'b1; prbs_chk_error_i = 1'b1; win_len_i = 16'd100;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      prbs_chk_error_i = (k == 22) || (k == 23);
      @(posedge clk_i); #1;
    end
    vectors++;
    if ({busy_o, locked_o, err_cnt_o} !== {2'b11, 16'd2}) begin
      miscompares++;
      $display("[TB] FAIL midrun_state: busy=%b locked=%b cnt=%0d, expected 1 1 2", busy_o, locked_o, err_cnt_o);
    end
    resetn_i = 1'b0;
    #1;
    vectors++;
    if ({busy_o, prbs_en_o, done_o, locked_o, pass_o, sync_fail_o, err_cnt_o, busyS, lockedS, cntS} !== 28'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset: got %b, expected all zero",
               {busy_o, prbs_en_o, done_o, locked_o, pass_o, sync_fail_o, err_cnt_o, busyS, lockedS, cntS});
    end
    @(posedge clk_i); #1;
    resetn_i = 1'b1;
    idle(2);
  endtask

  initial begin
    $display("[TB] prbs_err_monitor bench start");
    test_reset();
    test_clean_run();
    test_isolated_errors();
    test_sync_timeout();
    test_unlock_and_saturate();
    test_zero_window();
    test_abort();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
